// File: rtl/rr_stream_mux_if.sv
// rtl/rr_stream_mux_if.sv - N-to-1 stream mux handshake bundle
// Producer streams, forced-select controls and the consumer stream in one interface.
interface rr_stream_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-to-1 stream multiplexer with registered output
// Round-robin or forced channel selection feeding a single-entry output register.
module rr_stream_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_stream_mux_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD_W = 2 ** SEL_W;
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic              load;
  logic              xfer;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic [SEL_W:0]    scan;
  logic [PAD_W-1:0]  valid_pad;
  logic [PAD_W-1:0]  ready_pad;

  assign load = ~out_valid_q | bus.out_ready;
  assign xfer = grant_valid & load;

  // Zero-padding makes a forced index beyond NUM_CH-1 read as an idle channel.
  assign valid_pad = PAD_W'(bus.in_valid);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    if (bus.mode) begin
      grant_idx   = bus.sel;
      grant_valid = valid_pad[bus.sel];
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        scan = {1'b0, ptr_q} + (SEL_W + 1)'(i);
        if (scan >= NUM_CH_W) begin
          scan = scan - NUM_CH_W;
        end
        if (!grant_valid && valid_pad[scan[SEL_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = scan[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ready_pad = '0;
    if (rst_n && xfer) begin
      ready_pad[grant_idx] = 1'b1;
    end
  end

  assign bus.in_ready = ready_pad[NUM_CH-1:0];

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      if (!bus.mode) begin
        ptr_d = grant_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SEL_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - bench for rr_stream_mux
// Exercises a 4-channel and a 3-channel instance side by side.
module tb_rr_stream_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_stream_mux_if #(.NUM_CH(4), .DATA_W(8)) b4 ();
  rr_stream_mux_if #(.NUM_CH(3), .DATA_W(8)) b3 ();

  rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] ch;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic mode, input logic [1:0] sel, input logic [3:0] v,
                              input logic ordy, input logic [3:0] rdy, input logic ov,
                              input logic [1:0] ch, input logic [7:0] data);
    vec_t r;
    r.mode = mode; r.sel = sel; r.v = v; r.ordy = ordy;
    r.rdy = rdy; r.ov = ov; r.ch = ch; r.data = data;
    return r;
  endfunction

  // Reference model: channel order is plain modular arithmetic on a pointer.
  int          m_ptr[2], m_ov[2], m_ch[2], m_g[2], m_mode[2];
  int unsigned m_od[2], m_din[2];
  bit          m_fire[2];

  function automatic void arb(input int n, input int ptr, input int mode, input int sel,
                              input int v, output int g, output bit gv);
    g = 0;
    gv = 0;
    if (mode != 0) begin
      if (sel < n && ((v >> sel) & 1) == 1) begin g = sel; gv = 1; end
    end else begin
      for (int k = 1; k <= n; k++) begin
        if (!gv && ((v >> ((ptr + k) % n)) & 1) == 1) begin
          g = (ptr + k) % n;
          gv = 1;
        end
      end
    end
  endfunction

  task automatic model_pre(input int d, input int n, input int mode, input int sel, input int v,
                           input int ordy, input int unsigned din, input logic [31:0] act_rdy);
    int g;
    bit gv;
    bit load;
    arb(n, m_ptr[d], mode, sel, v, g, gv);
    load = (m_ov[d] == 0) || (ordy != 0);
    m_fire[d] = gv && load;
    m_g[d] = g;
    m_mode[d] = mode;
    m_din[d] = din;
    if (!m_fire[d] && ordy != 0) m_ov[d] = -1;
    chk($sformatf("rnd%0d_rdy", d), act_rdy, m_fire[d] ? (32'd1 << g) : 32'd0);
  endtask

  task automatic model_post(input int d, input logic [31:0] act_ov, input logic [31:0] act_ch,
                            input logic [31:0] act_od);
    if (m_fire[d]) begin
      m_od[d] = (m_din[d] >> (8 * m_g[d])) & 32'hFF;
      m_ch[d] = m_g[d];
      m_ov[d] = 1;
      if (m_mode[d] == 0) m_ptr[d] = m_g[d];
    end else if (m_ov[d] == -1) begin
      m_ov[d] = 0;
    end
    chk($sformatf("rnd%0d_ov", d), act_ov, m_ov[d]);
    chk($sformatf("rnd%0d_ch", d), act_ch, m_ch[d]);
    chk($sformatf("rnd%0d_data", d), act_od, m_od[d]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    b4.in_data = '0; b4.in_valid = 4'hF; b4.mode = 0; b4.sel = '0; b4.out_ready = 1;
    b3.in_data = '0; b3.in_valid = 3'h7; b3.mode = 0; b3.sel = '0; b3.out_ready = 1;
    #2;
    chk("reset_ov", b4.out_valid, 0);
    chk("reset_data", b4.out_data, 0);
    chk("reset_ch", b4.out_ch, 0);
    chk("reset_rdy4", b4.in_ready, 0);
    chk("reset_rdy3", b3.in_ready, 0);
    tick();
    rst_n = 1;
    b4.in_valid = 0;
    b3.in_valid = 0;
    b4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2));
    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b1000, 1, 3, 8'hA3));
    vecs.push_back(mk(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 0, 4'b0110, 1, 4'b0010, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b0110, 0, 4'b0000, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b0110, 0, 4'b0000, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b0110, 0, 4'b0000, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b0110, 1, 4'b0100, 1, 2, 8'hA2));
    vecs.push_back(mk(0, 0, 4'b0010, 1, 4'b0010, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b1010, 1, 4'b1000, 1, 3, 8'hA3));
    vecs.push_back(mk(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 0, 4'b1010, 1, 4'b1000, 1, 3, 8'hA3));
    vecs.push_back(mk(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 8'hA1));
    vecs.push_back(mk(1, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2));
    vecs.push_back(mk(1, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2));
    vecs.push_back(mk(1, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2));
    vecs.push_back(mk(0, 0, 4'b0101, 1, 4'b0100, 1, 2, 8'hA2));
    vecs.push_back(mk(0, 0, 4'b0101, 1, 4'b0001, 1, 0, 8'hA0));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 8'hA0));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 8'hA0));
    vecs.push_back(mk(1, 3, 4'b0111, 1, 4'b0000, 0, 0, 8'hA0));
    vecs.push_back(mk(0, 0, 4'b1000, 0, 4'b1000, 1, 3, 8'hA3));
    vecs.push_back(mk(1, 1, 4'b1111, 0, 4'b0000, 1, 3, 8'hA3));
    vecs.push_back(mk(1, 1, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1));

    foreach (vecs[i]) begin
      b4.mode = vecs[i].mode;
      b4.sel = vecs[i].sel;
      b4.in_valid = vecs[i].v;
      b4.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", i), b4.in_ready, vecs[i].rdy);
      tick();
      chk($sformatf("tbl%0d_out", i), {b4.out_valid, b4.out_ch, b4.out_data},
          {vecs[i].ov, vecs[i].ch, vecs[i].data});
    end

    // Idle gap, then a fresh beat on channel 0.
    b4.mode = 0; b4.in_valid = 0; b4.out_ready = 1;
    tick();
    tick();
    chk("idle_ov", b4.out_valid, 0);
    chk("idle_data_hold", b4.out_data, 8'hA1);
    b4.in_data[7:0] = 8'h5C;
    b4.in_valid = 4'b0001;
    tick();
    chk("idle_resume", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd0, 8'h5C});

    // Three-channel instance: forcing a nonexistent channel grants nothing.
    b3.in_data = {8'hB2, 8'hB1, 8'hB0};
    b3.mode = 1; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sel3_rdy%0d", i), b3.in_ready, 0);
      tick();
      chk($sformatf("sel3_ov%0d", i), b3.out_valid, 0);
    end
    b3.sel = 2'd2;
    #1;
    chk("sel2_rdy", b3.in_ready, 3'b100);
    tick();
    chk("sel2_out", {b3.out_valid, b3.out_ch, b3.out_data}, {1'b1, 2'd2, 8'hB2});
    b3.in_valid = 0; b3.mode = 0;

    // Asynchronous reset mid-cycle with a beat held.
    b4.in_valid = 4'b0001; b4.out_ready = 0;
    tick();
    chk("held_before_rst", {b4.out_valid, b4.out_ch, b4.out_data}, {1'b1, 2'd0, 8'h5C});
    b4.in_valid = 4'hF;
    #3;
    rst_n = 0;
    #1;
    chk("midrst_out", {b4.out_valid, b4.out_ch, b4.out_data}, 0);
    chk("midrst_rdy", b4.in_ready, 0);
    tick();
    rst_n = 1;
    b4.in_valid = 0;

    m_ptr[0] = 3; m_ptr[1] = 2;
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 0; m_ch[d] = 0; m_od[d] = 0;
    end

    for (int c = 0; c < 3000; c++) begin
      b4.in_valid = 4'($urandom);
      b4.mode = ($urandom_range(0, 3) == 0);
      b4.sel = 2'($urandom);
      b4.out_ready = ($urandom_range(0, 3) != 0);
      b4.in_data = 32'($urandom);
      b3.in_valid = 3'($urandom);
      b3.mode = ($urandom_range(0, 3) == 0);
      b3.sel = 2'($urandom);
      b3.out_ready = ($urandom_range(0, 2) != 0);
      b3.in_data = 24'($urandom);
      #1;
      model_pre(0, 4, int'(b4.mode), int'(b4.sel), int'(b4.in_valid), int'(b4.out_ready),
                32'(b4.in_data), 32'(b4.in_ready));
      model_pre(1, 3, int'(b3.mode), int'(b3.sel), int'(b3.in_valid), int'(b3.out_ready),
                32'(b3.in_data), 32'(b3.in_ready));
      tick();
      model_post(0, 32'(b4.out_valid), 32'(b4.out_ch), 32'(b4.out_data));
      model_post(1, 32'(b3.out_valid), 32'(b3.out_ch), 32'(b3.out_data));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
